// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-serial code-memory loader.
package loader_pkg;

  localparam int LOADER_MAX_WORDS = 64;
  localparam int BYTE_W           = 8;
  localparam int WORD_W           = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    WR   = 3'd4,
    CHK  = 3'd5,
    DONE = 3'd6,
    ERR  = 3'd7
  } state_e;

  // A frame must carry at least one word and no more than the memory holds.
  function automatic logic len_ok(input logic [BYTE_W-1:0] n);
    return (n != '0) && (n <= BYTE_W'(LOADER_MAX_WORDS));
  endfunction

endpackage

// File: rtl/code_loader.sv
// Framed byte-stream loader that assembles big-endian words into the code memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start, no load performed yet
// LEN   | waiting for the length byte
// HI    | waiting for the high byte of the next word
// LO    | waiting for the low byte of the next word
// WR    | one-cycle write strobe to the code memory
// CHK   | waiting for the checksum byte (checksum build only)
// DONE  | load complete, done flag held
// ERR   | frame rejected, error flag held
module code_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int CW = ADDR_W + 1;

  state_e            state_q, state_d;
  logic              rx_ready_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CW-1:0]     word_count_q;
  logic [CW-1:0]     len_q;
  logic              accept;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign accept    = rx_valid && rx_ready_q;
  assign last_word = (word_count_q + CW'(1)) == len_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN;
      LEN:  if (accept) state_d = len_ok(rx_data) ? HI : ERR;
      HI:   if (accept) state_d = LO;
      LO:   if (accept) state_d = WR;
`ifdef LOADER_CHECKSUM_EN
      WR:   state_d = last_word ? CHK : HI;
      CHK:  if (accept) state_d = (rx_data == sum_q) ? DONE : ERR;
`else
      WR:   state_d = last_word ? DONE : HI;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      mem_data_q   <= '0;
      mem_addr_q   <= '0;
      word_count_q <= '0;
      len_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_ready_q <= (state_d == LEN) || (state_d == HI) || (state_d == LO) || (state_d == CHK);
      busy_q     <= !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
      mem_we_q   <= (state_d == WR);
      if (state_d == DONE) done_q  <= 1'b1;
      if (state_d == ERR)  error_q <= 1'b1;

      case (state_q)
        IDLE, DONE, ERR: begin
          if (state_d == LEN) begin
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
            mem_addr_q   <= '0;
          end
        end
        LEN: begin
          if (accept) begin
            len_q <= rx_data[CW-1:0];
`ifdef LOADER_CHECKSUM_EN
            sum_q <= rx_data;
`endif
          end
        end
        HI: begin
          if (accept) begin
            mem_data_q[DATA_W-1 -: 8] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
            sum_q <= sum_q ^ rx_data;
`endif
          end
        end
        LO: begin
          if (accept) begin
            mem_data_q[7:0] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
            sum_q <= sum_q ^ rx_data;
`endif
          end
        end
        WR: begin
          // Address wraps to 0 after the 64th word; no further write follows.
          mem_addr_q   <= mem_addr_q + ADDR_W'(1);
          word_count_q <= word_count_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rx_ready   = rx_ready_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign mem_data   = mem_data_q;
  assign mem_addr   = mem_addr_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_code_loader.sv
// Directed self-checking bench for code_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_code_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] mem_data;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  word_count;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [15:0] mem_model [0:63];

  code_loader #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_we(mem_we),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Code-memory model: captures every write strobe, which must never coincide with rx_ready.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      mem_model[mem_addr] = mem_data;
      wr_cnt++;
      chk("ready_in_wr", {31'd0, rx_ready}, 32'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_data"}, {16'd0, mem_data}, 32'd0);
    chk({tag, "_mem_addr"}, {26'd0, mem_addr}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_word_count"}, {25'd0, word_count}, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte after an optional idle gap; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int n;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    n = 0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!done && !error && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_end_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    int base;
    int bad;
    logic [7:0] sum;
    logic [7:0] hi;
    logic [7:0] lo;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Two-word frame 02 12 34 AB CD
    pulse_start();
    chk("f1_busy", {31'd0, busy}, 32'd1);
    chk("f1_ready_len", {31'd0, rx_ready}, 32'd1);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h42, 0); // 02^12^34^AB^CD
`endif
    wait_end("f1");
    chk("f1_done", {31'd0, done}, 32'd1);
    chk("f1_error", {31'd0, error}, 32'd0);
    chk("f1_busy_end", {31'd0, busy}, 32'd0);
    chk("f1_word_count", {25'd0, word_count}, 32'd2);
    chk("f1_mem_addr", {26'd0, mem_addr}, 32'd2);
    chk("f1_writes", 32'(wr_cnt), 32'd2);
    chk("f1_word0", {16'd0, mem_model[0]}, 32'h1234);
    chk("f1_word1", {16'd0, mem_model[1]}, 32'hABCD);

    // Length 0 is rejected without any write
    base = wr_cnt;
    pulse_start();
    chk("len0_done_cleared", {31'd0, done}, 32'd0);
    send_byte(8'h00, 0);
    chk("len0_error", {31'd0, error}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("len0_ready", {31'd0, rx_ready}, 32'd0);
    chk("len0_done", {31'd0, done}, 32'd0);

    // Length 0x41 is one beyond the memory depth
    pulse_start();
    chk("len41_error_cleared", {31'd0, error}, 32'd0);
    send_byte(8'h41, 0);
    chk("len41_error", {31'd0, error}, 32'd1);
    chk("len41_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("len_err_writes", 32'(wr_cnt - base), 32'd0);

    // Full 64-word frame with random valid gaps
    base = wr_cnt;
    pulse_start();
    sum = 8'h40;
    send_byte(8'h40, 2);
    for (int i = 0; i < 64; i++) begin
      hi = 8'(i);
      lo = 8'(i) ^ 8'hA5;
      sum = sum ^ hi ^ lo;
      send_byte(hi, 2);
      send_byte(lo, 2);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum, 2);
`endif
    wait_end("full");
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_word_count", {25'd0, word_count}, 32'd64);
    chk("full_mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("full_writes", 32'(wr_cnt - base), 32'd64);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (mem_model[i] !== {8'(i), 8'(i) ^ 8'hA5}) bad++;
    end
    chk("full_contents_bad_words", 32'(bad), 32'd0);

    // Reset in the middle of the second word
    base = wr_cnt;
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_done_after", {31'd0, done}, 32'd0);
    chk("mid_busy_after", {31'd0, busy}, 32'd0);
    chk("mid_writes", 32'(wr_cnt - base), 32'd1);
    chk("mid_word0", {16'd0, mem_model[0]}, 32'h1122);

`ifdef LOADER_CHECKSUM_EN
    // Correct checksum 01^12^34 = 27
    mem_model[0] = 16'h0000;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h27, 0);
    wait_end("ck_ok");
    chk("ck_ok_done", {31'd0, done}, 32'd1);
    chk("ck_ok_error", {31'd0, error}, 32'd0);
    chk("ck_ok_word0", {16'd0, mem_model[0]}, 32'h1234);

    // Wrong checksum: frame rejected, written word remains
    mem_model[0] = 16'h0000;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h28, 0);
    wait_end("ck_bad");
    chk("ck_bad_error", {31'd0, error}, 32'd1);
    chk("ck_bad_done", {31'd0, done}, 32'd0);
    chk("ck_bad_word0", {16'd0, mem_model[0]}, 32'h1234);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
